touch_adc_responder: RTL

//  Synthesizable serial-slave model of the resistive-touch ADC (ADS7843-style), i.e. the far end of

---
 rtl/touch_adc_responder.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/touch_adc_responder.sv
// rtl/touch_adc_responder.sv - serial-slave model of an ADS7843-style resistive-touch ADC
module touch_adc_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int BUSY_CLKS   = 1
) (
    input  logic        i_cclk,
    input  logic        i_rstb,
    input  logic        i_touch_clk,
    input  logic        i_touch_csb,
    input  logic        i_data_in,
    output logic        o_data_out,
    output logic        o_touch_busy,
    input  logic [11:0] i_x_val,
    input  logic [11:0] i_y_val,
    input  logic [11:0] i_z_val,
    output logic [7:0]  o_last_cmd,
    output logic        o_cmd_valid,
    output logic [7:0]  o_conv_count
);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_BUSY, S_DATA} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_csb_sync;
    logic [SYNC_STAGES-1:0] r_din_sync;
    logic                   r_clk_dly;
    logic [7:0]             r_shreg;
    logic [3:0]             r_bit_cnt;
    logic [2:0]             r_busy_cnt;
    logic [11:0]            r_snap;

    logic        w_clk_s;
    logic        w_csb_s;
    logic        w_din_s;
    logic        w_rise;
    logic        w_fall;
    logic [7:0]  w_byte;
    logic        w_last_bit;
    logic        w_busy_done;
    logic [11:0] w_snap_nxt;
    logic        w_data_out_nxt;
    logic        w_busy_nxt;
    logic        w_cmd_valid_nxt;
    logic        w_cmd_load;
    logic        w_conv_inc;
    logic [7:0]  w_shreg_nxt;
    logic [3:0]  w_bit_cnt_nxt;
    logic [2:0]  w_busy_cnt_nxt;

    assign w_clk_s     = r_clk_sync[SYNC_STAGES-1];
    assign w_csb_s     = r_csb_sync[SYNC_STAGES-1];
    assign w_din_s     = r_din_sync[SYNC_STAGES-1];
    assign w_rise      = w_clk_s & ~r_clk_dly;
    assign w_fall      = ~w_clk_s & r_clk_dly;
    assign w_byte      = {r_shreg[6:0], w_din_s};
    assign w_last_bit  = (r_bit_cnt == 4'd7);
    assign w_busy_done = (r_busy_cnt == 3'(BUSY_CLKS));

    // Bring the master's pins into cclk; data_in shares the clock's latency so a rise sees its bit.
    always_ff @(posedge i_cclk or negedge i_rstb) begin
        if (!i_rstb) begin
            r_clk_sync <= '0;
            r_csb_sync <= '0;
            r_din_sync <= '0;
            r_clk_dly  <= 1'b0;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], i_touch_clk};
            r_csb_sync <= {r_csb_sync[SYNC_STAGES-2:0], i_touch_csb};
            r_din_sync <= {r_din_sync[SYNC_STAGES-2:0], i_data_in};
            r_clk_dly  <= w_clk_s;
        end
    end

    // Sample chosen by the channel field, truncated to 8 significant bits in MODE=1.
    always_comb begin
        case (w_byte[6:4])
            3'b101:  w_snap_nxt = i_x_val;
            3'b001:  w_snap_nxt = i_y_val;
            3'b011:  w_snap_nxt = i_z_val;
            default: w_snap_nxt = 12'h000;
        endcase
        if (w_byte[3]) w_snap_nxt[3:0] = 4'h0;
    end

    // State register.
    always_ff @(posedge i_cclk or negedge i_rstb) begin
        if (!i_rstb) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next state: chip-select deassertion overrides any clock edge seen in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        if (w_csb_s) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_rise && w_din_s)          w_state_nxt = S_CMD;
                S_CMD:   if (w_rise && w_last_bit)       w_state_nxt = S_BUSY;
                S_BUSY:  if (w_fall && w_busy_done)      w_state_nxt = S_DATA;
                S_DATA:  if (w_fall && r_bit_cnt == 4'd0) w_state_nxt = S_IDLE;
                default:                                  w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Per-state datapath and output updates: rises shift the command in, falls shift the result out.
    always_comb begin
        w_data_out_nxt  = o_data_out;
        w_busy_nxt      = o_touch_busy;
        w_cmd_valid_nxt = 1'b0;
        w_cmd_load      = 1'b0;
        w_conv_inc      = 1'b0;
        w_shreg_nxt     = r_shreg;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_busy_cnt_nxt  = r_busy_cnt;
        if (w_csb_s) begin
            w_data_out_nxt = 1'b0;
            w_busy_nxt     = 1'b0;
            w_bit_cnt_nxt  = 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_data_out_nxt = 1'b0;
                    if (w_rise && w_din_s) begin
                        w_shreg_nxt   = 8'd1;
                        w_bit_cnt_nxt = 4'd1;
                    end
                end
                S_CMD: begin
                    if (w_rise) begin
                        w_shreg_nxt    = w_byte;
                        w_bit_cnt_nxt  = r_bit_cnt + 4'd1;
                        w_busy_cnt_nxt = 3'd0;
                        if (w_last_bit) begin
                            w_cmd_valid_nxt = 1'b1;
                            w_cmd_load      = 1'b1;
                        end
                    end
                end
                S_BUSY: begin
                    if (w_fall) begin
                        if (!w_busy_done) begin
                            w_busy_nxt     = 1'b1;
                            w_busy_cnt_nxt = r_busy_cnt + 3'd1;
                        end else begin
                            w_busy_nxt     = 1'b0;
                            w_data_out_nxt = r_snap[11];
                            w_bit_cnt_nxt  = 4'd11;
                        end
                    end
                end
                S_DATA: begin
                    if (w_fall) begin
                        if (r_bit_cnt == 4'd0) begin
                            w_data_out_nxt = 1'b0;
                            w_conv_inc     = 1'b1;
                        end else begin
                            w_data_out_nxt = r_snap[r_bit_cnt - 4'd1];
                            w_bit_cnt_nxt  = r_bit_cnt - 4'd1;
                        end
                    end
                end
                default: w_data_out_nxt = 1'b0;
            endcase
        end
    end

    // Register the datapath; the snapshot is frozen on the eighth command rise.
    always_ff @(posedge i_cclk or negedge i_rstb) begin
        if (!i_rstb) begin
            o_data_out   <= 1'b0;
            o_touch_busy <= 1'b0;
            o_cmd_valid  <= 1'b0;
            o_last_cmd   <= 8'h00;
            o_conv_count <= 8'h00;
            r_shreg      <= 8'h00;
            r_bit_cnt    <= 4'd0;
            r_busy_cnt   <= 3'd0;
            r_snap       <= 12'h000;
        end else begin
            o_data_out   <= w_data_out_nxt;
            o_touch_busy <= w_busy_nxt;
            o_cmd_valid  <= w_cmd_valid_nxt;
            r_shreg      <= w_shreg_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_busy_cnt   <= w_busy_cnt_nxt;
            if (w_cmd_load) begin
                o_last_cmd <= w_byte;
                r_snap     <= w_snap_nxt;
            end
            if (w_conv_inc) o_conv_count <= o_conv_count + 8'd1;
        end
    end

endmodule
